// File: rtl/mcycle_pkg.sv
// Shared types and constants for the MCycle sequencer.
package mcycle_pkg;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 40;
  localparam int unsigned CNT_W_DEF          = 6;
  localparam int unsigned DATA_W             = 32;
  localparam int unsigned REG_ADDR_W         = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mcState_t;

  // Instruction context carried from E to the E/M register across the stall.
  typedef struct packed {
    logic [DATA_W-1:0]     instr;
    logic                  regWrite;
    logic                  memWrite;
    logic                  memtoReg;
    logic [DATA_W-1:0]     writeData;
    logic [REG_ADDR_W-1:0] ra2;
    logic [REG_ADDR_W-1:0] wa3;
  } mcCtx_t;

endpackage

// File: rtl/mcycle_ctx_reg.sv
// Context and result holding registers with the DONE-select output mux.
module mcycle_ctx_reg
  import mcycle_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ctxLoad,
  input  logic              resLoad,
  input  logic              doneSel,
  input  mcCtx_t            ctxIn,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] mcResult,
  output mcCtx_t            ctxOut,
  output logic [DATA_W-1:0] opResult
);

  mcCtx_t            ctxQ;
  logic [DATA_W-1:0] resQ;

  // Capture context at issue and the unit result at completion.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ctxQ <= '0;
      resQ <= '0;
    end else begin
      if (ctxLoad) ctxQ <= ctxIn;
      if (resLoad) resQ <= mcResult;
    end
  end

  // Saved values only in the completion cycle; E-stage values otherwise.
  always_comb begin
    ctxOut   = doneSel ? ctxQ : ctxIn;
    opResult = doneSel ? resQ : aluResult;
  end

endmodule

// File: rtl/mcycle_ctrl.sv
// Issue/stall/complete sequencer for the multi-cycle multiply/divide unit.
module mcycle_ctrl
  import mcycle_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             M_StartE,
  input  logic             Busy,
  input  logic [31:0]      MCycleResult,
  input  logic [31:0]      InstrE,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             MemtoRegE,
  input  logic [31:0]      WriteDataE,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [31:0]      ALUResultE,
  output logic             Start,
  output logic             StallMC,
  output logic             M_DoneE,
  output logic [31:0]      InstrRE,
  output logic             RegWriteRE,
  output logic             MemWriteRE,
  output logic             MemtoRegRE,
  output logic [31:0]      WriteDataRE,
  output logic [3:0]       RA2RE,
  output logic [3:0]       WA3RE,
  output logic [31:0]      OpResultRE,
  output logic             TimeoutErr,
  output logic [CNT_W-1:0] BusyCount
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  mcState_t state, nextState;
  logic     ctxLoad, resLoad, setTimeout, weMask, lastTimeout, doneSel;
  mcCtx_t   ctxIn, ctxOut;

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= nextState;
  end

  // Next state, issue/stall strobes and register load enables.
  always_comb begin
    nextState  = state;
    Start      = 1'b0;
    StallMC    = 1'b0;
    ctxLoad    = 1'b0;
    resLoad    = 1'b0;
    setTimeout = 1'b0;
    weMask     = 1'b1;
    case (state)
      IDLE: begin
        if (M_StartE) begin
          Start     = 1'b1;
          StallMC   = 1'b1;
          ctxLoad   = 1'b1;
          nextState = BUSY;
        end
      end
      BUSY: begin
        StallMC = 1'b1;
        weMask  = 1'b0;
        if (Busy && (BusyCount == CNT_LIMIT)) begin
          resLoad    = 1'b1;
          setTimeout = 1'b1;
          nextState  = DONE;
        end else if (!Busy && (BusyCount != '0)) begin
          resLoad   = 1'b1;
          nextState = DONE;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Busy-cycle counter, sticky watchdog flag and per-op timeout marker.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      BusyCount   <= '0;
      TimeoutErr  <= 1'b0;
      lastTimeout <= 1'b0;
    end else begin
      if (ctxLoad)            BusyCount <= '0;
      else if (state == BUSY) BusyCount <= BusyCount + CNT_W'(1);
      if (setTimeout)         TimeoutErr <= 1'b1;
      if (resLoad)            lastTimeout <= setTimeout;
    end
  end

  assign doneSel = (state == DONE);
  assign M_DoneE = doneSel;

  assign ctxIn = '{instr:     InstrE,
                   regWrite:  RegWriteE,
                   memWrite:  MemWriteE,
                   memtoReg:  MemtoRegE,
                   writeData: WriteDataE,
                   ra2:       RA2E,
                   wa3:       WA3E};

  mcycle_ctx_reg uCtxReg (
    .CLK       (CLK),
    .RESET     (RESET),
    .ctxLoad   (ctxLoad),
    .resLoad   (resLoad),
    .doneSel   (doneSel),
    .ctxIn     (ctxIn),
    .aluResult (ALUResultE),
    .mcResult  (MCycleResult),
    .ctxOut    (ctxOut),
    .opResult  (OpResultRE)
  );

  // Bubble during BUSY; a timed-out result never writes the register file.
  always_comb begin
    InstrRE     = ctxOut.instr;
    RegWriteRE  = ctxOut.regWrite & weMask & ~(doneSel & lastTimeout);
    MemWriteRE  = ctxOut.memWrite & weMask;
    MemtoRegRE  = ctxOut.memtoReg;
    WriteDataRE = ctxOut.writeData;
    RA2RE       = ctxOut.ra2;
    WA3RE       = ctxOut.wa3;
  end

endmodule
